mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM register.
// - Consumes the stage-4 bundle: ALU result, store data, rw and control bits.
// - Performs the data-memory access through a wait-state FSM and stalls upstream while the access is busy.
// - Drives the MEM/WB register (stage-5 outputs) that feeds write-back.
// PARAMETERS
// ADDR_W       10  word-address width; memory depth is 2**ADDR_W 32-bit words
// WAIT_CYCLES  1   extra clock edges per load/store; 0 means a single-edge access
// PORTS
// clk          in   1   pipeline clock; all state updates on negedge clk
// rst_n        in   1   asynchronous, active-low reset
// ALUout_4     in   32  byte address for loads/stores; result for ALU ops
// busB_4       in   32  store data
// rw_4         in   5   destination register
// MemWr_4      in   1   store request
// MemtoReg_4   in   1   load request (select memory data at WB)
// RegWr_4      in   1   register-write enable
// ALUout_5     out  32  registered ALU result
// Dout_5       out  32  registered load data
// rw_5         out  5   registered destination register
// MemtoReg_5   out  1   registered load select
// RegWr_5      out  1   registered write enable
// mem_exc_5    out  1   registered misaligned-access flag
// mem_stall    out  1   combinational; upstream holds the stage-4 bundle while it is 1
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE, wait counter=0.
//   - All stage-5 outputs are 0, so mem_stall=0.
//   - A pending store is discarded. RAM contents are not reset.
// - Access conditions:
//   - access = MemWr_4 | MemtoReg_4.
//   - aligned = (ALUout_4[1:0]==0).
//   - Word index = ALUout_4[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the depth.
// - FSM states IDLE and BUSY, with cnt of width clog2(WAIT_CYCLES+1).
// - IDLE, no access, or misaligned access:
//   - The bundle passes to stage 5 on the next edge.
//   - A misaligned access is not performed: RegWr_5=0, mem_exc_5=1, Dout_5=0.
//   - An ALU op passes with its own RegWr; Dout_5=0.
// - IDLE, aligned access, WAIT_CYCLES=0:
//   - The access completes on the same edge and mem_stall=0.
//   - Store: RAM[idx] <= busB_4.
//   - Load: Dout_5 <= RAM[idx] (old contents).
// - IDLE, aligned access, WAIT_CYCLES>0:
//   - mem_stall=1. Next edge: state=BUSY, cnt=WAIT_CYCLES-1.
//   - Stage 5 receives a bubble: RegWr_5=0, MemtoReg_5=0, rw_5=0, mem_exc_5=0.
// - BUSY with cnt!=0: mem_stall=1, cnt decrements, stage 5 receives a bubble.
// - BUSY with cnt==0:
//   - mem_stall=0.
//   - The access is performed on this edge and the bundle is transferred to stage 5.
//   - state=IDLE.
// - Latency: an aligned load/store reaches stage 5 after WAIT_CYCLES+1 edges. Non-memory ops take 1 edge.
// - Each store writes RAM exactly once, on its completion edge, even when the bundle is held across stalls.
// - MemWr_4 and MemtoReg_4 both set: treated as a store; MemtoReg_5=0, Dout_5=0.
// - Inputs may change only when mem_stall=0. Changes while BUSY are undefined, and a checker flags them.
// - A stage-5 bubble never has RegWr_5=1.
// STRUCTURE
// - pipe_pkg holds:
//   - WORD_W=32, REG_W=5.
//   - mem_state_t {IDLE, BUSY}.
//   - The bubble constant used for stage-5 output values.
// - Sub-module dmem: 2**ADDR_W x 32 RAM, write and read both synchronous on negedge clk, read returning the old contents.
// - Top level: FSM/counter, alignment check, MEM/WB output register.
// TESTING
// 1. WAIT=1; store 0xDEADBEEF @0x10, then load @0x10 -> mem_stall high 1 edge each; Dout_5=0xDEADBEEF, RegWr_5=1, rw_5 as given.
// 2. WAIT=3; load held 4 edges -> 3 bubble cycles (RegWr_5=0), then one valid result; RAM written once by a held store.
// 3. ALU op ALUout_4=0x1234, RegWr_4=1, rw_4=7 -> next edge ALUout_5=0x1234, RegWr_5=1, rw_5=7, no stall.
// 4. Load @0x13 (misaligned) -> no stall, mem_exc_5=1, RegWr_5=0, RAM unchanged.
// 5. Assert rst_n=0 while BUSY mid-store -> outputs 0 immediately, state IDLE, RAM word unchanged.
// 6. ADDR_W=10, store @0x1000 then load @0x0 -> same word (wrap); MemWr_4 & MemtoReg_4 -> store, MemtoReg_5=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline MEM stage: datapath widths,
// the MEM access FSM state encoding and the stage-5 bubble value.
package pipe_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    // Width of the stage-4 bundle that must stay stable while an access is held.
    localparam int BUNDLE_W = 2 * WORD_W + REG_W + 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Control/data portion of the MEM/WB register (load data lives in dmem).
    typedef struct packed {
        logic [WORD_W-1:0] alu;
        logic [REG_W-1:0]  rw;
        logic              mem_to_reg;
        logic              reg_wr;
        logic              exc;
    } s5_t;

    // A bubble writes nothing back and raises no exception.
    localparam s5_t S5_BUBBLE = '0;

    // Word accesses must sit on a 4-byte boundary.
    function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Loads win the MemtoReg select only when no store is requested.
    function automatic logic is_load(input logic mem_wr, input logic mem_to_reg);
        return mem_to_reg & ~mem_wr;
    endfunction

endpackage

// File: rtl/dmem.sv
// Data memory: 2**ADDR_W words, synchronous write and synchronous read on the
// falling clock edge. A read in the same edge as a write returns the old word.
// The read register clears to zero whenever no load is issued so that it can
// drive the load-data output of the MEM/WB register directly.
module dmem
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] r_mem [0:DEPTH-1];
    logic [WORD_W-1:0] r_rdata;

    // Write port: RAM contents are deliberately not reset.
    always_ff @(negedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Read port: old-data read, zero when no load completes on this edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: runs the data-memory access through an IDLE/BUSY wait-state FSM,
// stalls upstream while an aligned access is still waiting, flags misaligned
// accesses, and drives the MEM/WB register feeding write-back.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] ALUout_4,
    input  logic [WORD_W-1:0] busB_4,
    input  logic [REG_W-1:0]  rw_4,
    input  logic              MemWr_4,
    input  logic              MemtoReg_4,
    input  logic              RegWr_4,
    output logic [WORD_W-1:0] ALUout_5,
    output logic [WORD_W-1:0] Dout_5,
    output logic [REG_W-1:0]  rw_5,
    output logic              MemtoReg_5,
    output logic              RegWr_5,
    output logic              mem_exc_5,
    output logic              mem_stall
);

    // A zero-wait configuration still gets a 1-bit counter that is never loaded.
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    s5_t               r_s5;
    s5_t               w_s5_nxt;

    logic              w_access;
    logic              w_aligned;
    logic              w_misaligned;
    logic              w_complete;
    logic              w_stall_raw;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [ADDR_W-1:0] w_idx;
    logic [WORD_W-1:0] w_rdata;

    // Access decode; upper address bits are dropped so addresses wrap.
    assign w_access     = MemWr_4 | MemtoReg_4;
    assign w_aligned    = is_aligned(ALUout_4);
    assign w_misaligned = w_access & ~w_aligned;
    assign w_idx        = ALUout_4[ADDR_W+1:2];

    // An aligned access completes from IDLE only with no wait states,
    // otherwise on the BUSY edge where the counter has run out.
    assign w_complete = w_access & w_aligned &
                        (((r_state == IDLE) && (WAIT_CYCLES == 0)) ||
                         ((r_state == BUSY) && (r_cnt == '0)));

    // Hold upstream while an aligned access is pending but not completing.
    assign w_stall_raw = w_access & w_aligned & ~w_complete;

    // During reset the stage holds nothing, so it never asks for a stall.
    assign mem_stall = rst_n & w_stall_raw;

    // A store hits the RAM exactly once, on its completion edge.
    assign w_mem_we = rst_n & w_complete & MemWr_4;
    assign w_mem_re = w_complete & is_load(MemWr_4, MemtoReg_4);

    // FSM and wait counter next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_stall_raw) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            BUSY: begin
                if (w_stall_raw) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // MEM/WB next value: bubble while stalled, else the bundle with a
    // misaligned access turned into a non-writing exception.
    always_comb begin
        w_s5_nxt = S5_BUBBLE;
        if (!w_stall_raw) begin
            w_s5_nxt.alu        = ALUout_4;
            w_s5_nxt.rw         = rw_4;
            w_s5_nxt.mem_to_reg = is_load(MemWr_4, MemtoReg_4);
            w_s5_nxt.reg_wr     = RegWr_4 & ~w_misaligned;
            w_s5_nxt.exc        = w_misaligned;
        end
    end

    // MEM/WB register (control and ALU result).
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s5 <= S5_BUBBLE;
        end else begin
            r_s5 <= w_s5_nxt;
        end
    end

    dmem #(
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_idx   (w_idx),
        .i_wdata (busB_4),
        .o_rdata (w_rdata)
    );

    assign ALUout_5   = r_s5.alu;
    assign rw_5       = r_s5.rw;
    assign MemtoReg_5 = r_s5.mem_to_reg;
    assign RegWr_5    = r_s5.reg_wr;
    assign mem_exc_5  = r_s5.exc;
    assign Dout_5     = w_rdata;

    // Previous-edge copy of the bundle, used to detect illegal input changes
    // while an access is held in BUSY.
    logic [BUNDLE_W-1:0] w_bundle;
    logic [BUNDLE_W-1:0] r_held;

    assign w_bundle = {ALUout_4, busB_4, rw_4, MemWr_4, MemtoReg_4, RegWr_4};

    // Bundle snapshot register.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held <= '0;
        end else begin
            r_held <= w_bundle;
        end
    end

    a_bundle_stable_in_busy: assert property (
        @(negedge clk) disable iff (!rst_n)
        (r_state == BUSY) |-> (w_bundle == r_held)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (WAIT_CYCLES = 0, 1, 3), a vector table
// on the zero-wait instance and hand-written stall/reset sequences.
module tb_mem_stage;
    import pipe_pkg::*;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] bus_b;
        logic [4:0]  rw;
        logic        mem_wr;
        logic        mem_to_reg;
        logic        reg_wr;
    } in_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] dout;
        logic [4:0]  rw;
        logic        mtr;
        logic        rwr;
        logic        exc;
    } out_t;

    typedef struct packed {
        in_t  vin;
        out_t exp;
    } vec_t;

    int total;
    int bad;

    // Clock and reset block.
    logic clk;
    logic rn0, rn1, rn3;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    in_t  i0, i1, i3;
    out_t o0, o1, o3;
    logic st0, st1, st3;

    logic [31:0] a0, d0, a1, d1, a3, d3;
    logic [4:0]  r0, r1, r3;
    logic        m0, w0, e0, m1, w1, e1, m3, w3, e3;

    assign o0 = {a0, d0, r0, m0, w0, e0};
    assign o1 = {a1, d1, r1, m1, w1, e1};
    assign o3 = {a3, d3, r3, m3, w3, e3};

    mem_stage #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rn0),
        .ALUout_4(i0.alu), .busB_4(i0.bus_b), .rw_4(i0.rw),
        .MemWr_4(i0.mem_wr), .MemtoReg_4(i0.mem_to_reg), .RegWr_4(i0.reg_wr),
        .ALUout_5(a0), .Dout_5(d0), .rw_5(r0), .MemtoReg_5(m0),
        .RegWr_5(w0), .mem_exc_5(e0), .mem_stall(st0)
    );

    mem_stage #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rn1),
        .ALUout_4(i1.alu), .busB_4(i1.bus_b), .rw_4(i1.rw),
        .MemWr_4(i1.mem_wr), .MemtoReg_4(i1.mem_to_reg), .RegWr_4(i1.reg_wr),
        .ALUout_5(a1), .Dout_5(d1), .rw_5(r1), .MemtoReg_5(m1),
        .RegWr_5(w1), .mem_exc_5(e1), .mem_stall(st1)
    );

    mem_stage #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rn3),
        .ALUout_4(i3.alu), .busB_4(i3.bus_b), .rw_4(i3.rw),
        .MemWr_4(i3.mem_wr), .MemtoReg_4(i3.mem_to_reg), .RegWr_4(i3.reg_wr),
        .ALUout_5(a3), .Dout_5(d3), .rw_5(r3), .MemtoReg_5(m3),
        .RegWr_5(w3), .mem_exc_5(e3), .mem_stall(st3)
    );

    // Driver helpers.
    function automatic in_t mk_in(input logic [31:0] alu, input logic [31:0] b,
                                  input logic [4:0] rw, input logic wr,
                                  input logic mtr, input logic rwr);
        return {alu, b, rw, wr, mtr, rwr};
    endfunction

    function automatic out_t mk_out(input logic [31:0] alu, input logic [31:0] dout,
                                    input logic [4:0] rw, input logic mtr,
                                    input logic rwr, input logic exc);
        return {alu, dout, rw, mtr, rwr, exc};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard comparisons.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input out_t act, input out_t exp);
        chk({tag, ".ALUout_5"}, act.alu, exp.alu);
        chk({tag, ".Dout_5"}, act.dout, exp.dout);
        chk({tag, ".rw_5"}, 32'(act.rw), 32'(exp.rw));
        chk({tag, ".MemtoReg_5"}, 32'(act.mtr), 32'(exp.mtr));
        chk({tag, ".RegWr_5"}, 32'(act.rwr), 32'(exp.rwr));
        chk({tag, ".mem_exc_5"}, 32'(act.exc), 32'(exp.exc));
    endtask

    task automatic chk_bubble(input string tag, input out_t act);
        chk({tag, ".bub_RegWr_5"}, 32'(act.rwr), 32'd0);
        chk({tag, ".bub_MemtoReg_5"}, 32'(act.mtr), 32'd0);
        chk({tag, ".bub_rw_5"}, 32'(act.rw), 32'd0);
        chk({tag, ".bub_mem_exc_5"}, 32'(act.exc), 32'd0);
        chk({tag, ".bub_Dout_5"}, act.dout, 32'd0);
    endtask

    vec_t tbl [11];

    // Watchdog: the sequence below is bounded, this only catches a stuck sim.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rn0 = 1'b0; rn1 = 1'b0; rn3 = 1'b0;
        i0 = '0; i1 = '0; i3 = '0;

        // Zero-wait vectors: stores land on the edge, loads return old data.
        tbl[0]  = {mk_in(32'h1234, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1),
                   mk_out(32'h1234, 32'h0, 5'd7, 1'b0, 1'b1, 1'b0)};
        tbl[1]  = {mk_in(32'h10, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 1'b0),
                   mk_out(32'h10, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0)};
        tbl[2]  = {mk_in(32'h10, 32'h0, 5'd3, 1'b0, 1'b1, 1'b1),
                   mk_out(32'h10, 32'hDEADBEEF, 5'd3, 1'b1, 1'b1, 1'b0)};
        tbl[3]  = {mk_in(32'h13, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1),
                   mk_out(32'h13, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1)};
        tbl[4]  = {mk_in(32'h11, 32'h55555555, 5'd0, 1'b1, 1'b0, 1'b0),
                   mk_out(32'h11, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1)};
        tbl[5]  = {mk_in(32'h10, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1),
                   mk_out(32'h10, 32'hDEADBEEF, 5'd5, 1'b1, 1'b1, 1'b0)};
        tbl[6]  = {mk_in(32'h1000, 32'hCAFEF00D, 5'd0, 1'b1, 1'b0, 1'b0),
                   mk_out(32'h1000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0)};
        tbl[7]  = {mk_in(32'h0, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1),
                   mk_out(32'h0, 32'hCAFEF00D, 5'd9, 1'b1, 1'b1, 1'b0)};
        tbl[8]  = {mk_in(32'h20, 32'h0BADF00D, 5'd2, 1'b1, 1'b1, 1'b0),
                   mk_out(32'h20, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0)};
        tbl[9]  = {mk_in(32'h20, 32'h0, 5'd10, 1'b0, 1'b1, 1'b1),
                   mk_out(32'h20, 32'h0BADF00D, 5'd10, 1'b1, 1'b1, 1'b0)};
        tbl[10] = {mk_in(32'h3, 32'h0, 5'd31, 1'b0, 1'b0, 1'b1),
                   mk_out(32'h3, 32'h0, 5'd31, 1'b0, 1'b1, 1'b0)};

        // Reset state of all three instances.
        #3;
        chk_out("rst0", o0, '0);
        chk_out("rst1", o1, '0);
        chk_out("rst3", o3, '0);
        chk("rst0.stall", 32'(st0), 32'd0);
        chk("rst1.stall", 32'(st1), 32'd0);
        chk("rst3.stall", 32'(st3), 32'd0);
        #14;
        rn0 = 1'b1; rn1 = 1'b1; rn3 = 1'b1;
        tick();

        // Table-driven vectors on the zero-wait instance.
        for (int v = 0; v < 11; v++) begin
            i0 = tbl[v].vin;
            #1;
            chk($sformatf("vec%0d.stall", v), 32'(st0), 32'd0);
            tick();
            chk_out($sformatf("vec%0d", v), o0, tbl[v].exp);
        end
        i0 = '0;

        // One wait state: store then load, each stalls for one edge.
        i1 = mk_in(32'h10, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("w1_st.stall_pre", 32'(st1), 32'd1);
        tick();
        chk_bubble("w1_st", o1);
        chk("w1_st.stall_post", 32'(st1), 32'd0);
        tick();
        chk_out("w1_st.done", o1, mk_out(32'h10, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));

        i1 = mk_in(32'h10, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1);
        #1;
        chk("w1_ld.stall_pre", 32'(st1), 32'd1);
        tick();
        chk_bubble("w1_ld", o1);
        chk("w1_ld.stall_post", 32'(st1), 32'd0);
        tick();
        chk_out("w1_ld.done", o1, mk_out(32'h10, 32'hDEADBEEF, 5'd6, 1'b1, 1'b1, 1'b0));

        // ALU op never stalls and takes one edge.
        i1 = mk_in(32'h1234, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1);
        #1;
        chk("w1_alu.stall", 32'(st1), 32'd0);
        tick();
        chk_out("w1_alu", o1, mk_out(32'h1234, 32'h0, 5'd7, 1'b0, 1'b1, 1'b0));

        // Reset while a store is held in BUSY: no write, outputs cleared at once.
        i1 = mk_in(32'h80, 32'h00000077, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        i1 = mk_in(32'h80, 32'h00000099, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rbusy.stall_pre", 32'(st1), 32'd1);
        tick();
        chk("rbusy.state_busy", 32'(u_dut1.r_state), 32'(BUSY));
        rn1 = 1'b0;
        #1;
        chk_out("rbusy.out", o1, '0);
        chk("rbusy.stall", 32'(st1), 32'd0);
        chk("rbusy.state_idle", 32'(u_dut1.r_state), 32'(IDLE));
        i1 = '0;
        #2;
        rn1 = 1'b1;
        i1 = mk_in(32'h80, 32'h0, 5'd1, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        chk_out("rbusy.reload", o1, mk_out(32'h80, 32'h00000077, 5'd1, 1'b1, 1'b1, 1'b0));
        i1 = '0;

        // Three wait states: held store writes RAM once, on its last edge.
        i3 = mk_in(32'h40, 32'hAAAA0000, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        i3 = mk_in(32'h40, 32'h11112222, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("w3_st%0d.stall", k), 32'(st3), 32'd1);
            tick();
            chk_bubble($sformatf("w3_st%0d", k), o3);
            chk($sformatf("w3_st%0d.ram_old", k), u_dut3.u_dmem.r_mem[16], 32'hAAAA0000);
        end
        chk("w3_st.stall_last", 32'(st3), 32'd0);
        tick();
        chk_out("w3_st.done", o3, mk_out(32'h40, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
        chk("w3_st.ram_new", u_dut3.u_dmem.r_mem[16], 32'h11112222);

        i3 = mk_in(32'h40, 32'h0, 5'd8, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("w3_ld%0d.stall", k), 32'(st3), 32'd1);
            tick();
            chk_bubble($sformatf("w3_ld%0d", k), o3);
        end
        chk("w3_ld.stall_last", 32'(st3), 32'd0);
        tick();
        chk_out("w3_ld.done", o3, mk_out(32'h40, 32'h11112222, 5'd8, 1'b1, 1'b1, 1'b0));
        i3 = '0;
        tick();

        // Final report.
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
